vga_color_panel: RTL and testbench

- Downstream consumer of the 48-bit packed colour word from the colour decoder: four 12-bit RGB444 slots.
- Generates 640x480@60 Hz VGA timing from the 100 MHz system clock.
- Paints the four slots as four filled boxes side by side across the screen, with a background colour elsewhere.
- Drives the board VGA connector directly. The colour word is sampled once per frame, so a frame never shows a partial update.

---
 rtl/vga_color_panel.sv | 154 +++++++++++++++
 tb/tb_vga_color_panel.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/vga_color_panel.sv
// vga_color_panel: 640x480 VGA timing generator painting four colour boxes.
// Colour word is latched once per frame at the frame wrap.
module vga_color_panel #(
   parameter int          H_VISIBLE  = 640,
   parameter int          H_FP       = 16,
   parameter int          H_SYNC     = 96,
   parameter int          H_BP       = 48,
   parameter int          V_VISIBLE  = 480,
   parameter int          V_FP       = 10,
   parameter int          V_SYNC     = 2,
   parameter int          V_BP       = 33,
   parameter int          CLK_DIV    = 4,
   parameter int          BOX_MARGIN = 16,
   parameter int          BOX_TOP    = 160,
   parameter int          BOX_HEIGHT = 160,
   parameter logic [11:0] BG_COLOR   = 12'h000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [47:0] full_color,
   output logic        hsync,
   output logic        vsync,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int SLOT_PX = 160;

   logic [DIV_W-1:0] div_q;
   logic [9:0]       h_q;
   logic [9:0]       v_q;
   logic [47:0]      col_q;
   logic             hsync_q;
   logic             vsync_q;
   logic [11:0]      rgb_q;
   logic             fs_q;

   logic             pix_tick;
   logic             h_last;
   logic             v_last;
   logic [1:0]       slot;
   logic [9:0]       x_off;
   logic             visible;
   logic             in_box;
   logic [11:0]      rgb_d;
   logic             hsync_d;
   logic             vsync_d;

   assign pix_tick = (div_q == DIV_W'(CLK_DIV - 1));
   assign h_last   = (h_q == 10'(H_TOTAL - 1));
   assign v_last   = (v_q == 10'(V_TOTAL - 1));

   // Pixel colour and sync levels for the current (pre-advance) position.
   always_comb begin
      slot  = 2'd3;
      x_off = h_q - 10'(3 * SLOT_PX);
      if (h_q < 10'(SLOT_PX)) begin
         slot  = 2'd0;
         x_off = h_q;
      end else if (h_q < 10'(2 * SLOT_PX)) begin
         slot  = 2'd1;
         x_off = h_q - 10'(SLOT_PX);
      end else if (h_q < 10'(3 * SLOT_PX)) begin
         slot  = 2'd2;
         x_off = h_q - 10'(2 * SLOT_PX);
      end
      visible = (h_q < 10'(H_VISIBLE)) && (v_q < 10'(V_VISIBLE));
      in_box  = visible
              && (v_q >= 10'(BOX_TOP))
              && (v_q < 10'(BOX_TOP + BOX_HEIGHT))
              && (x_off >= 10'(BOX_MARGIN))
              && (x_off < 10'(SLOT_PX - BOX_MARGIN));
      rgb_d = 12'h000;
      if (in_box) begin
         unique case (slot)
            2'd0:    rgb_d = col_q[11:0];
            2'd1:    rgb_d = col_q[23:12];
            2'd2:    rgb_d = col_q[35:24];
            default: rgb_d = col_q[47:36];
         endcase
      end else if (visible) begin
         rgb_d = BG_COLOR;
      end
      hsync_d = !((h_q >= 10'(H_VISIBLE + H_FP))
               && (h_q < 10'(H_VISIBLE + H_FP + H_SYNC)));
      vsync_d = !((v_q >= 10'(V_VISIBLE + V_FP))
               && (v_q < 10'(V_VISIBLE + V_FP + V_SYNC)));
   end

   // Clock divider producing one pixel tick every CLK_DIV clocks.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_q <= '0;
      end else if (pix_tick) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + 1'b1;
      end
   end

   // Horizontal and vertical position counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         h_q <= '0;
         v_q <= '0;
      end else if (pix_tick) begin
         if (h_last) begin
            h_q <= '0;
            v_q <= v_last ? 10'd0 : v_q + 10'd1;
         end else begin
            h_q <= h_q + 10'd1;
         end
      end
   end

   // Registered video outputs, one pixel behind the counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         rgb_q   <= 12'h000;
      end else if (pix_tick) begin
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         rgb_q   <= rgb_d;
      end
   end

   // Per-frame colour latch and frame_start pulse at the frame wrap.
   always_ff @(posedge clk) begin
      if (reset) begin
         col_q <= '0;
         fs_q  <= 1'b0;
      end else begin
         fs_q <= pix_tick && h_last && v_last;
         if (pix_tick && h_last && v_last) begin
            col_q <= full_color;
         end
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign vga_r       = rgb_q[11:8];
   assign vga_g       = rgb_q[7:4];
   assign vga_b       = rgb_q[3:0];
   assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_color_panel.sv
// tb_vga_color_panel: directed checks of timing, boxes, background,
// per-frame colour latch and reset, on a shortened vertical frame.
module tb_vga_color_panel;

   localparam int CLK_DIV = 2;
   localparam int LINE    = 800;
   localparam int V_TOT   = 9;
   localparam int FRAME   = LINE * V_TOT;

   logic        clk = 1'b0;
   logic        reset;
   logic [47:0] full_color;
   logic        hsync;
   logic        vsync;
   logic [3:0]  vga_r;
   logic [3:0]  vga_g;
   logic [3:0]  vga_b;
   logic        frame_start;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   vga_color_panel #(
      .V_VISIBLE (6),
      .V_FP      (1),
      .V_SYNC    (1),
      .V_BP      (1),
      .CLK_DIV   (CLK_DIV),
      .BOX_TOP   (2),
      .BOX_HEIGHT(2),
      .BG_COLOR  (12'h333)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .full_color (full_color),
      .hsync      (hsync),
      .vsync      (vsync),
      .vga_r      (vga_r),
      .vga_g      (vga_g),
      .vga_b      (vga_b),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   // Clock edges since reset release; edge 1 is the first without reset.
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int t);
      int guard;
      guard = 0;
      while (cyc < t && guard < 200000) begin
         @(negedge clk);
         guard++;
      end
      if (cyc != t) begin
         n_chk++;
         n_err++;
         $display("FAIL sync: at cycle %0d, required %0d", cyc, t);
      end
   endtask

   // Outputs for pixel (x,y) of frame f appear after tick p+1.
   task automatic at_pix(input int f, input int x, input int y);
      wait_cyc(CLK_DIV * (f * FRAME + y * LINE + x + 1));
   endtask

   function automatic logic [15:0] rgb();
      return {4'h0, vga_r, vga_g, vga_b};
   endfunction

   initial begin
      reset      = 1'b1;
      full_color = 48'h0;
      repeat (5) @(negedge clk);
      chk("rst_hs", hsync, 1);
      chk("rst_vs", vsync, 1);
      chk("rst_rgb", rgb(), 12'h000);
      chk("rst_fs", frame_start, 0);
      full_color = 48'hFF000F0F0F00;
      reset      = 1'b0;

      at_pix(0, 655, 0); chk("hs_655", hsync, 1);
      at_pix(0, 656, 0); chk("hs_656", hsync, 0);
      at_pix(0, 751, 0); chk("hs_751", hsync, 0);
      at_pix(0, 752, 0); chk("hs_752", hsync, 1);
      at_pix(0, 8, 2);   chk("f0_bg", rgb(), 12'h333);
      at_pix(0, 80, 2);  chk("f0_black", rgb(), 12'h000);
      at_pix(0, 700, 2); chk("f0_blank", rgb(), 12'h000);
      at_pix(0, 799, 6); chk("vs_pre", vsync, 1);
      at_pix(0, 0, 7);   chk("vs_on", vsync, 0);
      at_pix(0, 799, 7); chk("vs_end", vsync, 0);
      at_pix(0, 0, 8);   chk("vs_off", vsync, 1);
      wait_cyc(CLK_DIV * FRAME - 1);     chk("fs_pre", frame_start, 0);
      wait_cyc(CLK_DIV * FRAME);         chk("fs_on", frame_start, 1);
      wait_cyc(CLK_DIV * FRAME + 1);     chk("fs_off", frame_start, 0);

      at_pix(1, 80, 1);  chk("f1_above", rgb(), 12'h333);
      at_pix(1, 15, 2);  chk("f1_x15", rgb(), 12'h333);
      at_pix(1, 16, 2);  chk("f1_x16", rgb(), 12'hF00);
      at_pix(1, 80, 2);  chk("f1_x80", rgb(), 12'hF00);
      at_pix(1, 143, 2); chk("f1_x143", rgb(), 12'hF00);
      at_pix(1, 144, 2); chk("f1_x144", rgb(), 12'h333);
      at_pix(1, 150, 2); chk("f1_x150", rgb(), 12'h333);
      at_pix(1, 176, 2); chk("f1_x176", rgb(), 12'h0F0);
      at_pix(1, 200, 2);
      full_color = {4{12'h00F}};
      at_pix(1, 240, 2); chk("f1_x240", rgb(), 12'h0F0);
      at_pix(1, 400, 2); chk("f1_x400", rgb(), 12'h00F);
      at_pix(1, 560, 2); chk("f1_x560", rgb(), 12'hFF0);
      at_pix(1, 700, 2); chk("f1_x700", rgb(), 12'h000);
      at_pix(1, 80, 3);  chk("f1_tear", rgb(), 12'hF00);
      at_pix(1, 80, 5);  chk("f1_below", rgb(), 12'h333);

      at_pix(2, 80, 2);  chk("f2_x80", rgb(), 12'h00F);
      at_pix(2, 560, 2); chk("f2_x560", rgb(), 12'h00F);
      at_pix(2, 300, 5); chk("f2_pre_rst", rgb(), 12'h333);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_hs", hsync, 1);
      chk("mid_vs", vsync, 1);
      chk("mid_rgb", rgb(), 12'h000);
      chk("mid_fs", frame_start, 0);
      reset = 1'b0;

      at_pix(0, 656, 0); chk("r_hs_656", hsync, 0);
      at_pix(0, 8, 2);   chk("r_bg", rgb(), 12'h333);
      at_pix(0, 80, 2);  chk("r_black", rgb(), 12'h000);
      at_pix(1, 80, 2);  chk("r_f1_x80", rgb(), 12'h00F);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
